decode_dispatch_queue: RTL and testbench

Parametrised decode/dispatch stage placed between the instruction fetcher and the ROB/RS/LSB back-end. It buffers fetched RV32I instructions in a circular queue, decodes the head entry, reads operands from the register file and dispatches in one registered step. The queue decouples the fetcher from back-end stalls. CDB operand bypass, a three-state JALR handler and flush handling are beyond the single-slot decoder it replaces.

---
 rtl/decode_dispatch_queue.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_decode_dispatch_queue.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_dispatch_queue
// Description : Circular instruction queue feeding an RV32I decoder that
//               reads register operands and dispatches one entry per cycle
//               to the ROB / RS / LSB. Handles JALR redirect (waiting on a
//               dependent rs1 when needed) and mispredict flush.
//               Optional macro DISPATCH_CDB_BYPASS_EN enables operand
//               capture from the common data bus during dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_dispatch_queue #(
    parameter int ROB_WIDTH_BIT = 5,
    parameter int IQ_DEPTH_BIT  = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       fq_valid,
    input  logic [95:0]                fq_data,
    output logic                       fq_ready,
    input  logic                       flush_in,
    input  logic [2:0]                 unit_full,
    input  logic [ROB_WIDTH_BIT-1:0]   rob_tail,
    output logic [9:0]                 ask_reg_ids,
    input  logic [63:0]                reg_vals,
    input  logic [1:0]                 reg_deps,
    input  logic [2*ROB_WIDTH_BIT-1:0] reg_robs,
    input  logic                       cdb_valid,
    input  logic [ROB_WIDTH_BIT-1:0]   cdb_rob_id,
    input  logic [31:0]                cdb_value,
    output logic [2:0]                 disp_valid,
    output logic [ROB_WIDTH_BIT+12:0]  disp_ctl,
    output logic [31:0]                disp_pc,
    output logic [31:0]                disp_value,
    output logic [31:0]                disp_imm,
    output logic [31:0]                disp_vj,
    output logic [31:0]                disp_vk,
    output logic [2*ROB_WIDTH_BIT+1:0] disp_q,
    output logic                       redirect_valid,
    output logic [31:0]                redirect_addr
);

    localparam int                    c_DEPTH   = 1 << IQ_DEPTH_BIT;
    localparam int                    c_RW      = ROB_WIDTH_BIT;
    localparam logic [IQ_DEPTH_BIT:0] c_PTR_ONE = {{IQ_DEPTH_BIT{1'b0}}, 1'b1};

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_WAIT_JALR = 2'd1,
        S_REDIRECT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [95:0]           r_mem [c_DEPTH];
    logic [IQ_DEPTH_BIT:0] r_head;
    logic [IQ_DEPTH_BIT:0] r_tail;

    // Queue status: equal indices with differing wrap bits means full
    logic w_empty, w_full, w_enq;
    assign w_empty  = (r_head == r_tail);
    assign w_full   = (r_head[IQ_DEPTH_BIT-1:0] == r_tail[IQ_DEPTH_BIT-1:0]) &&
                      (r_head[IQ_DEPTH_BIT] != r_tail[IQ_DEPTH_BIT]);
    assign fq_ready = !w_full && (r_state != S_REDIRECT) && !flush_in && rdy_in;
    assign w_enq    = fq_valid && fq_ready;

    // Head entry fields
    logic [95:0] w_head;
    logic [31:0] w_ins, w_pc, w_pred_pc;
    logic [2:0]  w_funct3;
    assign w_head      = r_mem[r_head[IQ_DEPTH_BIT-1:0]];
    assign w_ins       = w_head[31:0];
    assign w_pc        = w_head[63:32];
    assign w_pred_pc   = w_head[95:64];
    assign w_funct3    = w_ins[14:12];
    assign ask_reg_ids = {w_ins[24:20], w_ins[19:15]};

    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
    assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
    assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_imm_u = {w_ins[31:12], 12'd0};
    assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

    // Operand sources, optionally captured from the CDB when still pending
    logic [31:0]     w_rs1_val, w_rs2_val;
    logic            w_rs1_dep, w_rs2_dep;
    logic [c_RW-1:0] w_rs1_rob, w_rs2_rob;
    assign w_rs1_rob = reg_robs[c_RW-1:0];
    assign w_rs2_rob = reg_robs[2*c_RW-1:c_RW];
`ifdef DISPATCH_CDB_BYPASS_EN
    logic w_hit1, w_hit2;
    assign w_hit1    = reg_deps[0] && cdb_valid && (cdb_rob_id == w_rs1_rob);
    assign w_hit2    = reg_deps[1] && cdb_valid && (cdb_rob_id == w_rs2_rob);
    assign w_rs1_val = w_hit1 ? cdb_value : reg_vals[31:0];
    assign w_rs2_val = w_hit2 ? cdb_value : reg_vals[63:32];
    assign w_rs1_dep = reg_deps[0] && !w_hit1;
    assign w_rs2_dep = reg_deps[1] && !w_hit2;
`else
    logic w_unused_cdb;
    assign w_unused_cdb = ^{cdb_valid, cdb_rob_id, cdb_value};
    assign w_rs1_val    = reg_vals[31:0];
    assign w_rs2_val    = reg_vals[63:32];
    assign w_rs1_dep    = reg_deps[0];
    assign w_rs2_dep    = reg_deps[1];
`endif

    logic [2:0]      w_need;
    logic            w_ready, w_is_jalr, w_use_rs1, w_use_rs2, w_imm_as_vk;
    logic [4:0]      w_rd, w_op;
    logic [1:0]      w_rob_type;
    logic [31:0]     w_imm, w_value, w_vj, w_vk;
    logic            w_qj_valid, w_qk_valid;
    logic [c_RW-1:0] w_qj, w_qk;

    // Combinational RV32I decode of the head entry; unknown encodings become ROB-only NOPs
    always_comb begin
        w_need      = 3'b001;
        w_ready     = 1'b0;
        w_is_jalr   = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_imm_as_vk = 1'b0;
        w_rd        = w_ins[11:7];
        w_op        = 5'd0;
        w_rob_type  = 2'b00;
        w_imm       = 32'd0;
        w_value     = 32'd0;
        case (w_ins[6:0])
            c_OP_REG: begin
                w_need    = 3'b011;
                w_op      = {1'b0, w_ins[30], w_funct3};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OP_IMM: begin
                w_need      = 3'b011;
                w_use_rs1   = 1'b1;
                w_imm_as_vk = 1'b1;
                w_op        = {1'b0, (w_funct3 == 3'b101) ? w_ins[30] : 1'b0, w_funct3};
                w_imm       = (w_funct3[1:0] == 2'b01) ? {27'd0, w_ins[24:20]} : w_imm_i;
            end
            c_OP_BRANCH: begin
                w_need     = 3'b011;
                w_rob_type = 2'b10;
                w_rd       = 5'd0;
                w_op       = {2'b10, w_funct3};
                w_imm      = w_imm_b;
                w_value    = w_pred_pc;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
            end
            c_OP_LOAD: begin
                w_need     = 3'b101;
                w_rob_type = 2'b11;
                w_op       = {2'b00, w_funct3};
                w_imm      = w_imm_i;
                w_use_rs1  = 1'b1;
            end
            c_OP_STORE: begin
                w_need     = 3'b101;
                w_rob_type = 2'b01;
                w_rd       = 5'd0;
                w_op       = {2'b01, w_funct3};
                w_imm      = w_imm_s;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
            end
            c_OP_JAL: begin
                w_ready = 1'b1;
                w_imm   = w_imm_j;
                w_value = w_pc + 32'd4;
            end
            c_OP_JALR: begin
                w_ready   = 1'b1;
                w_is_jalr = 1'b1;
                w_imm     = w_imm_i;
                w_value   = w_pc + 32'd4;
            end
            c_OP_LUI: begin
                w_ready = 1'b1;
                w_imm   = w_imm_u;
                w_value = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_ready = 1'b1;
                w_imm   = w_imm_u;
                w_value = w_pc + w_imm_u;
            end
            default: begin
                w_ready = 1'b1;
                w_rd    = 5'd0;
            end
        endcase
        w_vj       = w_use_rs1 ? w_rs1_val : 32'd0;
        w_qj_valid = w_use_rs1 && w_rs1_dep;
        w_qj       = w_qj_valid ? w_rs1_rob : '0;
        w_vk       = w_imm_as_vk ? w_imm : (w_use_rs2 ? w_rs2_val : 32'd0);
        w_qk_valid = w_use_rs2 && w_rs2_dep;
        w_qk       = w_qk_valid ? w_rs2_rob : '0;
    end

    logic        w_jalr_wait, w_issue;
    logic [31:0] w_jalr_target;
    assign w_jalr_wait   = w_is_jalr && w_rs1_dep;
    assign w_jalr_target = (w_rs1_val + w_imm_i) & ~32'd1;
    assign w_issue       = !w_empty && ((w_need & unit_full) == 3'b000) &&
                           (r_state != S_REDIRECT) && !w_jalr_wait;

    // Next-state logic for the JALR handling FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                if (w_issue && w_is_jalr)
                    w_state_next = S_REDIRECT;
                else if (!w_empty && w_jalr_wait)
                    w_state_next = S_WAIT_JALR;
            end
            S_WAIT_JALR: begin
                if (w_issue)
                    w_state_next = S_REDIRECT;
                else if (!w_jalr_wait)
                    w_state_next = S_RUN;
            end
            S_REDIRECT: w_state_next = S_RUN;
            default:    w_state_next = S_RUN;
        endcase
    end

    // FSM state register; flush forces RUN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_state <= S_RUN;
        else if (rdy_in)
            r_state <= flush_in ? S_RUN : w_state_next;
    end

    // Queue storage; contents need no reset because pointers gate validity
    always_ff @(posedge clk_in) begin
        if (w_enq)
            r_mem[r_tail[IQ_DEPTH_BIT-1:0]] <= fq_data;
    end

    // Queue pointers and registered dispatch / redirect outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head         <= '0;
            r_tail         <= '0;
            disp_valid     <= 3'b000;
            disp_ctl       <= '0;
            disp_pc        <= 32'd0;
            disp_value     <= 32'd0;
            disp_imm       <= 32'd0;
            disp_vj        <= 32'd0;
            disp_vk        <= 32'd0;
            disp_q         <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= 32'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_head         <= '0;
                r_tail         <= '0;
                disp_valid     <= 3'b000;
                redirect_valid <= 1'b0;
            end else begin
                disp_valid     <= w_issue ? w_need : 3'b000;
                redirect_valid <= w_issue && w_is_jalr;
                if (w_issue) begin
                    r_head     <= r_head + c_PTR_ONE;
                    disp_ctl   <= {w_ready, rob_tail, w_rd, w_op, w_rob_type};
                    disp_pc    <= w_pc;
                    disp_value <= w_value;
                    disp_imm   <= w_imm;
                    disp_vj    <= w_vj;
                    disp_vk    <= w_vk;
                    disp_q     <= {w_qk_valid, w_qj_valid, w_qk, w_qj};
                end
                // A dispatched JALR discards everything younger, including this cycle's enqueue
                if (w_issue && w_is_jalr) begin
                    r_tail        <= r_head + c_PTR_ONE;
                    redirect_addr <= w_jalr_target;
                end else if (w_enq) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_dispatch_queue
// Description : Self-checking bench for decode_dispatch_queue. A queue-based
//               reference model decodes entries from the RV32I encoding rules
//               and predicts every registered output; directed scenarios are
//               followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_dispatch_queue;

    localparam int RW = 5;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in, fq_valid, fq_ready, flush_in;
    logic [95:0]       fq_data;
    logic [2:0]        unit_full;
    logic [RW-1:0]     rob_tail;
    logic [9:0]        ask_reg_ids;
    logic [63:0]       reg_vals;
    logic [1:0]        reg_deps;
    logic [2*RW-1:0]   reg_robs;
    logic              cdb_valid;
    logic [RW-1:0]     cdb_rob_id;
    logic [31:0]       cdb_value;
    logic [2:0]        disp_valid;
    logic [RW+12:0]    disp_ctl;
    logic [31:0]       disp_pc, disp_value, disp_imm, disp_vj, disp_vk;
    logic [2*RW+1:0]   disp_q;
    logic              redirect_valid;
    logic [31:0]       redirect_addr;

    decode_dispatch_queue #(.ROB_WIDTH_BIT(RW), .IQ_DEPTH_BIT(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .fq_valid(fq_valid), .fq_data(fq_data), .fq_ready(fq_ready),
        .flush_in(flush_in), .unit_full(unit_full), .rob_tail(rob_tail),
        .ask_reg_ids(ask_reg_ids), .reg_vals(reg_vals), .reg_deps(reg_deps),
        .reg_robs(reg_robs), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .disp_valid(disp_valid), .disp_ctl(disp_ctl),
        .disp_pc(disp_pc), .disp_value(disp_value), .disp_imm(disp_imm),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_q(disp_q),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [2:0]      need;
        logic [RW+12:0]  ctl;
        logic [31:0]     pc, value, imm, vj, vk, jaddr;
        logic [2*RW+1:0] q;
        bit              jalr, jwait;
    } dec_t;

    logic [95:0]     mq[$];
    int              mst;            // 0 running, 1 waiting on JALR rs1, 2 redirecting
    logic [2:0]      e_valid;
    logic [RW+12:0]  e_ctl;
    logic [31:0]     e_pc, e_value, e_imm, e_vj, e_vk, e_ra;
    logic [2*RW+1:0] e_q;
    logic            e_rv;

    task automatic model_reset();
        mq.delete();
        mst = 0; e_valid = 0; e_ctl = 0; e_pc = 0; e_value = 0; e_imm = 0;
        e_vj = 0; e_vk = 0; e_q = 0; e_rv = 0; e_ra = 0;
    endtask

    // Decode an entry from the instruction-set rules, using the current operand inputs
    function automatic dec_t model_decode(input logic [95:0] e);
        dec_t        d;
        logic [31:0] ins, pc, sI, sS, sB, sU, sJ, v1, v2;
        logic        d1, d2, usej, usek, rdy;
        logic [4:0]  rd, op;
        logic [1:0]  rt;
        logic [2:0]  f3;
        d = '{default: '0};
        ins = e[31:0]; pc = e[63:32]; f3 = ins[14:12];
        sI = {{20{ins[31]}}, ins[31:20]};
        sS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        sB = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        sU = ins & 32'hFFFF_F000;
        sJ = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        v1 = reg_vals[31:0]; v2 = reg_vals[63:32];
        d1 = reg_deps[0];    d2 = reg_deps[1];
`ifdef DISPATCH_CDB_BYPASS_EN
        if (d1 && cdb_valid && cdb_rob_id == reg_robs[RW-1:0]) begin v1 = cdb_value; d1 = 0; end
        if (d2 && cdb_valid && cdb_rob_id == reg_robs[2*RW-1:RW]) begin v2 = cdb_value; d2 = 0; end
`endif
        rd = ins[11:7]; op = 0; rt = 0; rdy = 0; usej = 0; usek = 0; d.need = 3'b001;
        case (ins[6:0])
            7'h33: begin d.need = 3'b011; op = {1'b0, ins[30], f3}; usej = 1; usek = 1; end
            7'h13: begin
                d.need = 3'b011; usej = 1;
                op = {1'b0, (f3 == 3'b101) & ins[30], f3};
                d.imm = (f3 == 3'b001 || f3 == 3'b101) ? 32'(ins[24:20]) : sI;
            end
            7'h63: begin d.need = 3'b011; rt = 2; rd = 0; op = {2'b10, f3}; d.imm = sB;
                         d.value = e[95:64]; usej = 1; usek = 1; end
            7'h03: begin d.need = 3'b101; rt = 3; op = {2'b00, f3}; d.imm = sI; usej = 1; end
            7'h23: begin d.need = 3'b101; rt = 1; rd = 0; op = {2'b01, f3}; d.imm = sS;
                         usej = 1; usek = 1; end
            7'h6f: begin rdy = 1; d.imm = sJ; d.value = pc + 4; end
            7'h67: begin rdy = 1; d.imm = sI; d.value = pc + 4; d.jalr = 1; d.jwait = d1;
                         d.jaddr = (v1 + sI) & 32'hFFFF_FFFE; end
            7'h37: begin rdy = 1; d.imm = sU; d.value = sU; end
            7'h17: begin rdy = 1; d.imm = sU; d.value = pc + sU; end
            default: begin rdy = 1; rd = 0; end
        endcase
        d.pc = pc;
        d.vj = usej ? v1 : 0;
        d.vk = (ins[6:0] == 7'h13) ? d.imm : (usek ? v2 : 0);
        d.q  = {usek && d2, usej && d1,
                (usek && d2) ? reg_robs[2*RW-1:RW] : RW'(0),
                (usej && d1) ? reg_robs[RW-1:0] : RW'(0)};
        d.ctl = {rdy, rob_tail, rd, op, rt};
        return d;
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic tick();
        logic exp_rdy, enq, issue;
        dec_t d;
        int   nst;
        #1;
        exp_rdy = (mq.size() < 4) && (mst != 2) && !flush_in && rdy_in;
        check_value("fq_ready", fq_ready, exp_rdy);
        if (mq.size() > 0)
            check_value("ask_reg_ids", ask_reg_ids, {mq[0][24:20], mq[0][19:15]});
        if (rdy_in) begin
            if (flush_in) begin
                mq.delete(); e_valid = 0; e_rv = 0; mst = 0;
            end else begin
                enq = fq_valid && exp_rdy;
                issue = 0;
                d = '{default: '0};
                if (mq.size() > 0) begin
                    d = model_decode(mq[0]);
                    issue = ((d.need & unit_full) == 0) && (mst != 2) && !d.jwait;
                end
                e_valid = issue ? d.need : 3'b000;
                e_rv = issue && d.jalr;
                if (issue) begin
                    e_ctl = d.ctl; e_pc = d.pc; e_value = d.value; e_imm = d.imm;
                    e_vj = d.vj; e_vk = d.vk; e_q = d.q;
                    if (d.jalr) e_ra = d.jaddr;
                end
                if (issue && d.jalr) nst = 2;
                else if (mst == 2) nst = 0;
                else if (mq.size() > 0 && d.jalr && d.jwait) nst = 1;
                else nst = 0;
                if (issue) void'(mq.pop_front());
                if (issue && d.jalr) mq.delete();
                else if (enq) mq.push_back(fq_data);
                mst = nst;
            end
        end
        @(posedge clk_in);
        #1;
        check_value("disp_valid", disp_valid, e_valid);
        check_value("redirect_valid", redirect_valid, e_rv);
        if (e_valid != 0) begin
            check_value("disp_ctl", disp_ctl, e_ctl);
            check_value("disp_pc", disp_pc, e_pc);
            check_value("disp_value", disp_value, e_value);
            check_value("disp_imm", disp_imm, e_imm);
            check_value("disp_vj", disp_vj, e_vj);
            check_value("disp_vk", disp_vk, e_vk);
            check_value("disp_q", disp_q, e_q);
        end
        if (e_rv) check_value("redirect_addr", redirect_addr, e_ra);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_valid"}, disp_valid, 0);
        check_value({tag, "_ctl"}, disp_ctl, 0);
        check_value({tag, "_pc"}, disp_pc, 0);
        check_value({tag, "_value"}, disp_value, 0);
        check_value({tag, "_imm"}, disp_imm, 0);
        check_value({tag, "_vj"}, disp_vj, 0);
        check_value({tag, "_vk"}, disp_vk, 0);
        check_value({tag, "_q"}, disp_q, 0);
        check_value({tag, "_rv"}, redirect_valid, 0);
        check_value({tag, "_ra"}, redirect_addr, 0);
    endtask

    task automatic quiet();
        rdy_in = 1; flush_in = 0; fq_valid = 0; fq_data = 0; unit_full = 0;
        rob_tail = 0; reg_vals = 0; reg_deps = 0; reg_robs = 0;
        cdb_valid = 0; cdb_rob_id = 0; cdb_value = 0;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h37, 7'h17};
        logic [31:0] ins;
        int          k;
        ins = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) ins[6:0] = ops[k];
        return ins;
    endfunction

    task automatic rand_inputs();
        rdy_in     = ($urandom % 10) != 0;
        flush_in   = ($urandom % 30) == 0;
        fq_valid   = ($urandom % 4) != 0;
        fq_data    = {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC, rand_ins()};
        unit_full  = {($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0};
        rob_tail   = RW'($urandom);
        reg_vals   = {32'($urandom), 32'($urandom)};
        reg_deps   = 2'($urandom);
        reg_robs   = {RW'($urandom % 4), RW'($urandom % 4)};
        cdb_valid  = 1'($urandom);
        cdb_rob_id = RW'($urandom % 4);
        cdb_value  = $urandom;
    endtask

    initial begin
        quiet();
        rst_in = 1;
        model_reset();
        #2;
        check_all_zero("reset");
        @(posedge clk_in); #1;
        rst_in = 0;

        // ADDI x1,x0,5 at pc 0 dispatched the cycle after acceptance
        fq_valid = 1; fq_data = {32'h4, 32'h0, 32'h0050_0093}; rob_tail = 5'd7;
        tick();
        fq_valid = 0;
        tick();
        check_value("addi_valid", disp_valid, 3'b011);
        check_value("addi_rd", disp_ctl[11:7], 5'd1);
        check_value("addi_vk", disp_vk, 32'd5);
        check_value("addi_qkv", disp_q[2*RW+1], 1'b0);
        check_value("addi_rob", disp_ctl[RW+11:12], 5'd7);

        // Fill the queue while the RS is full, then drain in order
        unit_full = 3'b010;
        for (int i = 0; i < 4; i++) begin
            fq_valid = 1; fq_data = {32'h0, 32'(i * 4), {12'(i + 1), 5'd0, 3'b000, 5'(i + 2), 7'h13}};
            tick();
        end
        #1;
        check_value("full_ready", fq_ready, 1'b0);
        fq_valid = 0; unit_full = 3'b000;
        for (int i = 0; i < 5; i++) tick();
        #1;
        check_value("drain_ready", fq_ready, 1'b1);

        // SW x5,12(x6)
        fq_valid = 1; fq_data = {32'h0, 32'h10, {7'd0, 5'd5, 5'd6, 3'b010, 5'd12, 7'h23}};
        reg_vals = {32'h55, 32'h66};
        tick();
        fq_valid = 0;
        tick();
        check_value("sw_valid", disp_valid, 3'b101);
        check_value("sw_type", disp_ctl[1:0], 2'b01);
        check_value("sw_op", disp_ctl[6:2], 5'b01010);
        check_value("sw_imm", disp_imm, 32'd12);
        check_value("sw_rd", disp_ctl[11:7], 5'd0);

        // JALR x1,8(x2) with x2 = 0x100 ready, pc 0x40; next enqueue must be refused
        fq_valid = 1; fq_data = {32'h0, 32'h40, {12'd8, 5'd2, 3'b000, 5'd1, 7'h67}};
        reg_vals = {32'h0, 32'h100};
        tick();
        fq_data = {32'h0, 32'h44, 32'h0050_0093};
        tick();
        check_value("jalr_rv", redirect_valid, 1'b1);
        check_value("jalr_addr", redirect_addr, 32'h108);
        check_value("jalr_value", disp_value, 32'h44);
        check_value("jalr_ready", fq_ready, 1'b0);
        tick();
        fq_valid = 0;
        tick();

        // JALR waiting on ROB 3 while the CDB broadcasts it
        fq_valid = 1; fq_data = {32'h0, 32'h80, {12'd8, 5'd2, 3'b000, 5'd1, 7'h67}};
        reg_vals = {32'h0, 32'h100}; reg_deps = 2'b01; reg_robs = {5'd0, 5'd3};
        cdb_valid = 1; cdb_rob_id = 5'd3; cdb_value = 32'h200;
        tick();
        fq_valid = 0;
        tick();
        tick();
        cdb_valid = 0; reg_deps = 2'b00; reg_vals = {32'h0, 32'h200};
        tick(); tick(); tick();

        // Flush with three queued entries and a concurrent offer
        quiet();
        unit_full = 3'b001;
        for (int i = 0; i < 3; i++) begin
            fq_valid = 1; fq_data = {32'h0, 32'(i * 4), 32'h0050_0093};
            tick();
        end
        flush_in = 1;
        tick();
        flush_in = 0; fq_valid = 0; unit_full = 0;
        tick(); tick();

        // Randomized traffic with an asynchronous reset partway through
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            tick();
            if (c == 1500) begin
                #1 rst_in = 1;
                #1;
                model_reset();
                check_all_zero("midreset");
                rst_in = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
